gpio_ctrl: RTL and testbench

Parametrised GPIO controller and successor to the fixed two-in/two-out GPIO block. It provides NIN synchronised input channels and NOUT writable output registers over a word-addressed bus, plus per-bit edge detection with maskable, sticky, write-1-to-clear interrupt status. It sits on the SoC memory-mapped bus and drives a single level interrupt line to the CPU.

---
 rtl/gpio_ctrl.sv | 100 ++++++++++
 tb/tb_gpio_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: NIN synchronised inputs, NOUT output registers,
// per-bit edge detection with sticky write-1-to-clear status and a masked level irq.
module gpio_ctrl #(
    parameter int WIDTH = 32,
    parameter int NIN   = 2,
    parameter int NOUT  = 2,
    parameter int AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         A,
    input  logic                  WE,
    input  logic [WIDTH-1:0]      WD,
    input  logic [NIN*WIDTH-1:0]  gpI,
    output logic [WIDTH-1:0]      RD,
    output logic [NOUT*WIDTH-1:0] gpO,
    output logic                  irq
);

    localparam int NB = NIN * WIDTH;
    localparam int B1 = NIN;
    localparam int B2 = NIN + NOUT;
    localparam int B3 = 2 * NIN + NOUT;
    localparam int B4 = 3 * NIN + NOUT;

    logic [NB-1:0]         s1_q, s1_d;
    logic [NB-1:0]         s2_q, s2_d;
    logic [NB-1:0]         p_q, p_d;
    logic [NB-1:0]         ie_q, ie_d;
    logic [NB-1:0]         is_q, is_d;
    logic [NOUT*WIDTH-1:0] out_q, out_d;
    logic [1:0]            edge_q, edge_d;

    logic [NB-1:0] rise, fall, ev, clr;
    logic [31:0]   addr;

    assign addr = 32'(A);

    always_comb begin
        s1_d   = gpI;
        s2_d   = s1_q;
        p_d    = s2_q;
        out_d  = out_q;
        ie_d   = ie_q;
        edge_d = edge_q;
        clr    = '0;
        rise   = s2_q & ~p_q;
        fall   = ~s2_q & p_q;
        ev     = (rise & {NB{edge_q[0]}}) | (fall & {NB{edge_q[1]}});
        if (WE) begin
            for (int j = 0; j < NOUT; j++) begin
                if (addr == 32'(B1 + j)) out_d[j*WIDTH +: WIDTH] = WD;
            end
            for (int k = 0; k < NIN; k++) begin
                if (addr == 32'(B2 + k)) ie_d[k*WIDTH +: WIDTH] = WD;
                if (addr == 32'(B3 + k)) clr[k*WIDTH +: WIDTH] = WD;
            end
            if (addr == 32'(B4)) edge_d = WD[1:0];
        end
        // A new event on a bit outranks a simultaneous clear of that bit
        is_d = (is_q & ~clr) | ev;
    end

    always_comb begin
        RD = '0;
        for (int k = 0; k < NIN; k++) begin
            if (addr == 32'(k))      RD = s2_q[k*WIDTH +: WIDTH];
            if (addr == 32'(B2 + k)) RD = ie_q[k*WIDTH +: WIDTH];
            if (addr == 32'(B3 + k)) RD = is_q[k*WIDTH +: WIDTH];
        end
        for (int j = 0; j < NOUT; j++) begin
            if (addr == 32'(B1 + j)) RD = out_q[j*WIDTH +: WIDTH];
        end
        if (addr == 32'(B4)) RD = {{(WIDTH-2){1'b0}}, edge_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            p_q    <= '0;
            ie_q   <= '0;
            is_q   <= '0;
            out_q  <= '0;
            edge_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            p_q    <= p_d;
            ie_q   <= ie_d;
            is_q   <= is_d;
            out_q  <= out_d;
            edge_q <= edge_d;
        end
    end

    assign gpO = out_q;
    assign irq = |(is_q & ie_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: stimulus queues expected values, a negedge
// monitor pops and compares them against RD / gpO / irq.
module tb_gpio_ctrl;

    localparam int WIDTH = 32;
    localparam int NIN   = 2;
    localparam int NOUT  = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [AW-1:0]         A;
    logic                  WE;
    logic [WIDTH-1:0]      WD;
    logic [NIN*WIDTH-1:0]  gpI;
    logic [WIDTH-1:0]      RD;
    logic [NOUT*WIDTH-1:0] gpO;
    logic                  irq;

    gpio_ctrl #(.WIDTH(WIDTH), .NIN(NIN), .NOUT(NOUT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .A(A), .WE(WE), .WD(WD),
        .gpI(gpI), .RD(RD), .gpO(gpO), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        logic [63:0]  exp;
        logic [127:0] nm;
    } chk_t;

    chk_t q[$];
    int   total = 0;
    int   bad   = 0;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        it;
            logic [63:0] act;
            it = q.pop_front();
            case (it.kind)
                0:       act = {32'b0, RD};
                1:       act = gpO;
                default: act = {63'b0, irq};
            endcase
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %0s actual=%h expected=%h", it.nm, act, it.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [63:0] exp, input logic [127:0] nm);
        q.push_back('{kind, exp, nm});
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        A  = AW'(a);
        WD = d;
        WE = 1'b1;
        cyc();
        WE = 1'b0;
    endtask

    task automatic exp_rd(input int a, input logic [31:0] e, input logic [127:0] nm);
        A = AW'(a);
        push(0, {32'b0, e}, nm);
        cyc();
    endtask

    task automatic exp_gpo(input logic [63:0] e, input logic [127:0] nm);
        push(1, e, nm);
    endtask

    task automatic exp_irq(input logic e, input logic [127:0] nm);
        push(2, {63'b0, e}, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; A = '0; WE = 1'b0; WD = '0; gpI = '0;
        exp_gpo(64'h0, "rst_gpo");
        exp_irq(1'b0, "rst_irq");
        cyc(); cyc();
        rst = 1'b1;

        // reset state of the whole map
        for (int a = 0; a <= 9; a++) exp_rd(a, 32'h0, "rst_rd");
        exp_gpo(64'h0, "rst_gpo2");
        exp_irq(1'b0, "rst_irq2");
        cyc();

        // output registers, read-old-during-write, IN writes ignored
        wr(3, 32'hDEADBEEF);
        exp_gpo({32'hDEADBEEF, 32'h0}, "out1_gpo");
        exp_rd(3, 32'hDEADBEEF, "out1_rd");
        A = AW'(2); WD = 32'h12345678; WE = 1'b1;
        push(0, 64'h0, "out0_old");
        cyc();
        WE = 1'b0;
        exp_rd(2, 32'h12345678, "out0_new");
        exp_gpo({32'hDEADBEEF, 32'h12345678}, "out_gpo");
        wr(0, 32'hFFFFFFFF);
        exp_rd(0, 32'h0, "in0_wr_ign");

        // rising edge on gpI[0]
        wr(8, 32'h1);
        wr(4, 32'h1);
        gpI[0] = 1'b1;
        exp_rd(0, 32'h0, "in0_e0");
        exp_rd(0, 32'h0, "in0_e1");
        exp_irq(1'b0, "irq_e2");
        exp_rd(0, 32'h1, "in0_e2");
        A = AW'(6);
        exp_irq(1'b1, "irq_e3");
        exp_rd(6, 32'h1, "is0_e3");
        cyc(); cyc(); cyc();
        exp_rd(6, 32'h1, "is0_hold");

        // write-1-to-clear
        wr(6, 32'h0);
        exp_irq(1'b1, "irq_w0");
        exp_rd(6, 32'h1, "is0_w0");
        wr(6, 32'h1);
        exp_irq(1'b0, "irq_w1c");
        exp_rd(6, 32'h0, "is0_w1c");

        // falling edge on gpI[37] with both edges enabled
        wr(8, 32'h3);
        exp_rd(8, 32'h3, "edge_rd");
        gpI[37] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        wr(7, 32'h20);
        exp_rd(7, 32'h0, "is1_clr");
        gpI[37] = 1'b0;
        cyc(); cyc(); cyc();
        exp_irq(1'b0, "irq_masked");
        exp_rd(7, 32'h20, "is1_fall");

        // W1C coinciding with a new fall event
        gpI[37] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        gpI[37] = 1'b0;
        cyc(); cyc();
        A = AW'(7); WD = 32'h20; WE = 1'b1;
        cyc();
        WE = 1'b0;
        exp_rd(7, 32'h20, "is1_setwins");

        // enabling IE on a set bit
        wr(5, 32'h20);
        exp_irq(1'b1, "irq_ie1");
        wr(9, 32'hFFFFFFFF);
        exp_rd(9, 32'h0, "oob_rd");

        // async reset mid-operation
        wr(2, 32'h55);
        exp_gpo({32'hDEADBEEF, 32'h00000055}, "out0_55");
        exp_irq(1'b1, "irq_pre_rst");
        cyc();
        gpI = '0;
        rst = 1'b0;
        #1;
        exp_gpo(64'h0, "rst_async_gpo");
        exp_irq(1'b0, "rst_async_irq");
        cyc();
        rst = 1'b1;
        for (int a = 0; a <= 9; a++) exp_rd(a, 32'h0, "post_rst_rd");

        cyc(); cyc();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
